// File: rtl/window_motor_drive.sv
// window_motor_drive: turns open/close command levels into H-bridge direction
// drives. It stops on the end-of-travel limits and inserts a dead time before
// any reversal. It latches a fault on a run timeout or on contradictory limits.
module window_motor_drive #(
    parameter int unsigned RUN_TIMEOUT = 5_000_000,
    parameter int unsigned DEAD_TIME   = 1000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic clk,
    input  logic n_reset,
    input  logic open_cw,
    input  logic close_ccw,
    input  logic limit_open,
    input  logic limit_closed,
    output logic motor_cw,
    output logic motor_ccw,
    output logic busy,
    output logic fault
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN_CW  = 3'd1,
        S_RUN_CCW = 3'd2,
        S_DEAD    = 3'd3,
        S_FAULT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        P_NONE = 2'd0,
        P_CW   = 2'd1,
        P_CCW  = 2'd2
    } pend_e;

    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME - 1);

    state_e           state_q;
    pend_e            pend_q;
    pend_e            pend_d;
    logic [CNT_W-1:0] cnt_q;

    logic cw_only_c;
    logic ccw_only_c;
    logic both_limits_c;

    // Command and limit decode shared by every state.
    assign cw_only_c     = open_cw & ~close_ccw;
    assign ccw_only_c    = close_ccw & ~open_cw;
    assign both_limits_c = limit_open & limit_closed;

    // Pending direction as seen this cycle: the latest single-direction command wins.
    always_comb begin
        pend_d = pend_q;
        if (cw_only_c) begin
            pend_d = P_CW;
        end else if (ccw_only_c) begin
            pend_d = P_CCW;
        end
    end

    // Control FSM with registered drive and status outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= S_IDLE;
            pend_q    <= P_NONE;
            cnt_q     <= '0;
            motor_cw  <= 1'b0;
            motor_ccw <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else if (state_q != S_FAULT && both_limits_c) begin
            state_q   <= S_FAULT;
            pend_q    <= P_NONE;
            motor_cw  <= 1'b0;
            motor_ccw <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cw_only_c && !limit_open) begin
                        state_q  <= S_RUN_CW;
                        cnt_q    <= '0;
                        motor_cw <= 1'b1;
                        busy     <= 1'b1;
                    end else if (ccw_only_c && !limit_closed) begin
                        state_q   <= S_RUN_CCW;
                        cnt_q     <= '0;
                        motor_ccw <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_RUN_CW: begin
                    if (limit_open) begin
                        state_q  <= S_DEAD;
                        pend_q   <= P_NONE;
                        cnt_q    <= '0;
                        motor_cw <= 1'b0;
                    end else if (cnt_q == RUN_LAST) begin
                        state_q  <= S_FAULT;
                        motor_cw <= 1'b0;
                        busy     <= 1'b0;
                        fault    <= 1'b1;
                    end else if (ccw_only_c) begin
                        state_q  <= S_DEAD;
                        pend_q   <= P_CCW;
                        cnt_q    <= '0;
                        motor_cw <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RUN_CCW: begin
                    if (limit_closed) begin
                        state_q   <= S_DEAD;
                        pend_q    <= P_NONE;
                        cnt_q     <= '0;
                        motor_ccw <= 1'b0;
                    end else if (cnt_q == RUN_LAST) begin
                        state_q   <= S_FAULT;
                        motor_ccw <= 1'b0;
                        busy      <= 1'b0;
                        fault     <= 1'b1;
                    end else if (cw_only_c) begin
                        state_q   <= S_DEAD;
                        pend_q    <= P_CW;
                        cnt_q     <= '0;
                        motor_ccw <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DEAD: begin
                    if (cnt_q == DEAD_LAST) begin
                        pend_q <= P_NONE;
                        cnt_q  <= '0;
                        if (pend_d == P_CW && !limit_open) begin
                            state_q  <= S_RUN_CW;
                            motor_cw <= 1'b1;
                        end else if (pend_d == P_CCW && !limit_closed) begin
                            state_q   <= S_RUN_CCW;
                            motor_ccw <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        pend_q <= pend_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                S_FAULT: begin
                    motor_cw  <= 1'b0;
                    motor_ccw <= 1'b0;
                    busy      <= 1'b0;
                    fault     <= 1'b1;
                end
                default: begin
                    state_q   <= S_IDLE;
                    pend_q    <= P_NONE;
                    cnt_q     <= '0;
                    motor_cw  <= 1'b0;
                    motor_ccw <= 1'b0;
                    busy      <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_motor_drive.sv
// Bench for window_motor_drive: directed stimulus queues the expected
// outputs by cycle number, and a separate monitor pops and compares them.
module tb_window_motor_drive;

    localparam int unsigned RT = 20;
    localparam int unsigned DT = 4;

    logic clk = 1'b0;
    logic n_reset;
    logic open_cw;
    logic close_ccw;
    logic limit_open;
    logic limit_closed;
    logic motor_cw;
    logic motor_ccw;
    logic busy;
    logic fault;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    window_motor_drive #(
        .RUN_TIMEOUT(RT),
        .DEAD_TIME  (DT),
        .CNT_W      (24)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .open_cw     (open_cw),
        .close_ccw   (close_ccw),
        .limit_open  (limit_open),
        .limit_closed(limit_closed),
        .motor_cw    (motor_cw),
        .motor_ccw   (motor_ccw),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Count rising edges so that expectations can be keyed to a cycle number.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] outs();
        return {motor_cw, motor_ccw, busy, fault};
    endfunction

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cw/ccw/busy/fault got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input int unsigned off, input logic [3:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + off;
        e.exp  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic expect_span(input int unsigned from, input int unsigned to,
                               input logic [3:0] v, input string nm);
        for (int unsigned k = from; k <= to; k++) expect_at(k, v, nm);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare due expectations and check that the drives are never both high.
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc != cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d checked late at %0d", e.name, e.cyc, cyc);
            end else begin
                check(e.name, outs(), e.exp);
            end
        end
        n_checks++;
        if (motor_cw && motor_ccw) begin
            n_fail++;
            $display("FAIL drive_exclusive: motor_cw=%b motor_ccw=%b expected not both 1 (cycle %0d)",
                     motor_cw, motor_ccw, cyc);
        end
    end

    // Run time limit.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected the bench to finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset      = 1'b0;
        open_cw      = 1'b0;
        close_ccw    = 1'b0;
        limit_open   = 1'b0;
        limit_closed = 1'b0;

        // Reset held with random inputs: outputs stay 0.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            expect_at(1, 4'b0000, "reset_hold");
            {open_cw, close_ccw, limit_open, limit_closed} = 4'($urandom);
            step(1);
        end
        {open_cw, close_ccw, limit_open, limit_closed} = 4'b0000;
        n_reset = 1'b1;
        step(1);

        // First run after reset, then a normal open that ends on limit_open.
        open_cw = 1'b1;
        expect_span(1, 10, 4'b1010, "open_run");
        step(1);
        open_cw = 1'b0;
        step(9);
        limit_open = 1'b1;
        expect_span(1, 4, 4'b0010, "open_dead");
        expect_at(5, 4'b0000, "open_idle");
        step(5);
        limit_open = 1'b0;
        step(1);

        // Reversal: CW run, close pulse, 4 dead cycles, then CCW.
        open_cw = 1'b1;
        expect_span(1, 4, 4'b1010, "rev_cw");
        step(1);
        open_cw = 1'b0;
        step(3);
        close_ccw = 1'b1;
        expect_span(1, 4, 4'b0010, "rev_dead");
        expect_span(5, 7, 4'b0110, "rev_ccw");
        step(1);
        close_ccw = 1'b0;
        step(6);
        limit_closed = 1'b1;
        expect_span(1, 4, 4'b0010, "close_dead");
        expect_at(5, 4'b0000, "close_idle");
        step(5);

        // Ignored commands: close toward an asserted limit, then both commands high.
        close_ccw = 1'b1;
        expect_span(1, 2, 4'b0000, "ign_at_limit");
        step(2);
        close_ccw    = 1'b0;
        limit_closed = 1'b0;
        open_cw      = 1'b1;
        close_ccw    = 1'b1;
        expect_span(1, 3, 4'b0000, "ign_both_cmds");
        step(3);
        open_cw   = 1'b0;
        close_ccw = 1'b0;
        step(1);

        // open_cw held for 30 cycles: a single run that ends at limit_open.
        open_cw = 1'b1;
        expect_span(1, 14, 4'b1010, "held_run");
        step(14);
        limit_open = 1'b1;
        expect_span(1, 4, 4'b0010, "held_dead");
        expect_span(5, 16, 4'b0000, "held_idle");
        step(16);
        open_cw    = 1'b0;
        limit_open = 1'b0;
        step(1);

        // Timeout: drive high for exactly 20 cycles, then fault is sticky.
        open_cw = 1'b1;
        expect_span(1, RT, 4'b1010, "to_run");
        expect_span(RT + 1, RT + 4, 4'b0001, "to_fault");
        step(1);
        open_cw = 1'b0;
        step(RT + 3);
        close_ccw = 1'b1;
        expect_span(1, 2, 4'b0001, "fault_sticky_ccw");
        step(1);
        close_ccw = 1'b0;
        open_cw   = 1'b1;
        step(1);
        open_cw = 1'b0;
        expect_span(1, 2, 4'b0001, "fault_sticky_cw");
        step(2);
        #2;
        n_reset = 1'b0;
        #1;
        check("fault_cleared_by_reset", outs(), 4'b0000);
        step(1);
        n_reset = 1'b1;
        step(1);

        // Both limits high during RUN_CCW: fault on the next edge.
        close_ccw = 1'b1;
        expect_span(1, 2, 4'b0110, "bl_ccw");
        step(1);
        close_ccw = 1'b0;
        step(1);
        limit_open   = 1'b1;
        limit_closed = 1'b1;
        expect_span(1, 3, 4'b0001, "bl_fault");
        step(3);
        limit_open   = 1'b0;
        limit_closed = 1'b0;
        #2;
        n_reset = 1'b0;
        #1;
        check("bl_reset", outs(), 4'b0000);
        step(1);
        n_reset = 1'b1;
        step(1);

        // Reset asserted mid-run drops the drive with no clock edge.
        open_cw = 1'b1;
        expect_span(1, 3, 4'b1010, "mr_run");
        step(1);
        open_cw = 1'b0;
        step(2);
        #3;
        n_reset = 1'b0;
        #1;
        check("midrun_async_reset", outs(), 4'b0000);
        step(1);
        n_reset = 1'b1;

        // Every queued expectation must have been consumed.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) step(1);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_motor_drive.md
# window_motor_drive

Downstream stage of the window open/close state machine: converts its `open_cw` / `close_ccw` command levels into registered motor-direction drives. Stops on end-of-travel limit switches, inserts a dead time before any direction reversal, and latches a fault on run timeout or contradictory limits. Outputs go directly to the H-bridge gate logic.

## Interface
- `RUN_TIMEOUT`, default 5_000_000: maximum cycles the motor may run in one direction before fault.
- `DEAD_TIME`, default 1000: cycles both drives are held low after any stop, before a new run may start; must be ≥1.
- `CNT_W`, default 24: counter width; must hold max(RUN_TIMEOUT, DEAD_TIME).
- `clk` in 1: single clock; all logic is on its rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `open_cw` in 1: open command level from the window FSM; synchronous to `clk`.
- `close_ccw` in 1: close command level from the window FSM; synchronous to `clk`.
- `limit_open` in 1: high when the window is fully open.
- `limit_closed` in 1: high when the window is fully closed.
- `motor_cw` out 1: drive the motor in the opening direction.
- `motor_ccw` out 1: drive the motor in the closing direction.
- `busy` out 1: high in RUN_CW, RUN_CCW and DEAD.
- `fault` out 1: sticky fault flag; cleared only by reset.

## Operation
- **States:** IDLE, RUN_CW, RUN_CCW, DEAD, FAULT.
- **Registers:**
  - One `CNT_W` counter, shared by the run and dead-time phases.
  - A 2-bit pending-direction register (none / CW / CCW).
- **Outputs:** all registered. `motor_cw` and `motor_ccw` are never high together in any state.
- **IDLE:**
  - `open_cw`=1, `close_ccw`=0 and `limit_open`=0: go to RUN_CW and clear the counter.
  - `close_ccw`=1, `open_cw`=0 and `limit_closed`=0: go to RUN_CCW and clear the counter.
  - Both commands high: ignored.
  - Command toward an already-asserted limit: ignored.
- **RUN_CW** (`motor_cw`=1), in priority order:
  1. `limit_open`=1: go to DEAD, pending = none.
  2. Counter = RUN_TIMEOUT-1: go to FAULT.
  3. `close_ccw`=1 and `open_cw`=0: go to DEAD, pending = CCW.
  4. Otherwise stay and increment the counter.
  - A same-direction command is ignored; a held level does not restart the timeout.
- **RUN_CCW:** mirror of RUN_CW, using `limit_closed` and `open_cw`.
- **DEAD** (both drives 0):
  - On entry, clear the counter.
  - A new single-direction command overwrites pending (latest wins); both commands high leaves pending unchanged.
  - When the counter reaches DEAD_TIME-1:
    - pending CW and `limit_open`=0: go to RUN_CW.
    - pending CCW and `limit_closed`=0: go to RUN_CCW.
    - Otherwise go to IDLE.
  - Pending is cleared on exit.
- **FAULT:** both drives 0, `fault`=1, `busy`=0. No command leaves it; only `n_reset` does.
- **Global rule:** `limit_open` and `limit_closed` both high in any non-FAULT state means FAULT on the next edge. This rule has priority over all other transitions.
- **Reset:**
  - Asserting `n_reset` immediately (asynchronously) forces IDLE, counter 0, pending none, and all outputs 0 (`motor_cw`, `motor_ccw`, `busy`, `fault`).
  - Reset asserted mid-run stops the motor with no dead time.
  - After deassertion, the first edge evaluates IDLE rules.

## Timing
- **Command to drive:** a command sampled at edge N asserts the drive after edge N (visible in cycle N+1). Latency is 1 cycle.
- **Limit to stop:** a limit sampled at edge N deasserts the drive after edge N. Latency is 1 cycle.
- **Timeout:** an uninterrupted run holds the drive high for exactly RUN_TIMEOUT cycles; `fault` rises in the same cycle the drive falls.
- **Dead time:** both drives are low for exactly DEAD_TIME cycles between a stop and any following run.
- **Reversal gap:** the opposite drive rises DEAD_TIME+1 cycles after the reversing command is sampled.
- **Counter:** never wraps; terminal compares use equality to the parameter minus 1.

## Test plan
All scenarios use RUN_TIMEOUT=20 and DEAD_TIME=4.
- **Reset values:** hold reset with random inputs → all outputs 0. Release, then pulse `open_cw` 1 cycle → `motor_cw`=1 from the next cycle and `busy`=1.
- **Normal open:** `open_cw` pulse, then `limit_open` rises 10 cycles later → `motor_cw` falls 1 cycle after the limit. `busy` stays high 4 more cycles, then IDLE; `fault`=0.
- **Reversal:** in RUN_CW, pulse `close_ccw` → `motor_cw` drops next cycle, both drives stay low exactly 4 cycles, then `motor_ccw`=1. `motor_cw` and `motor_ccw` are never high together.
- **Timeout:** `open_cw` pulse with no limit → `motor_cw` high exactly 20 cycles, then `fault`=1 sticky. Further commands have no effect; `n_reset` clears the fault.
- **Ignored commands:**
  - `close_ccw` with `limit_closed`=1 in IDLE → no drive.
  - `open_cw` and `close_ccw` high together in IDLE → no drive.
  - `open_cw` held high 30 cycles → single run, ending at `limit_open` or timeout.
- **Both limits and mid-run reset:**
  - `limit_open` and `limit_closed` high together during RUN_CCW → FAULT next cycle with drives 0.
  - Separate run: assert `n_reset` mid-RUN_CW → `motor_cw` drops immediately, with no clock edge needed.
